// File: rtl/freq_duty_meter.sv
// Measures period and high time of an asynchronous divided clock in i_clk_in cycles.
// One result per complete input period, strobed with o_meas_valid.
module freq_duty_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk_in,
   input  logic             i_rst_n,
   input  logic             i_sig_in,
   input  logic             i_meas_en,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high_time,
   output logic             o_meas_valid,
   output logic             o_timeout_err,
   output logic             o_busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;
   localparam logic [1:0] ST_LOW  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sigDly;
   logic                   w_sig;
   logic                   w_rise;
   logic                   w_fall;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_hiReg;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_highTime;
   logic             r_measValid;
   logic             r_timeoutErr;

   // Rise and fall share the same pipeline depth, so measured widths carry no bias.
   always_ff @(posedge i_clk_in or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync   <= '0;
         r_sigDly <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
         r_sigDly <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_sig  = r_sync[SYNC_STAGES-1];
   assign w_rise = w_sig & ~r_sigDly;
   assign w_fall = ~w_sig & r_sigDly;

   always_ff @(posedge i_clk_in or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= CNT_ZERO;
         r_hiReg      <= CNT_ZERO;
         r_period     <= CNT_ZERO;
         r_highTime   <= CNT_ZERO;
         r_measValid  <= 1'b0;
         r_timeoutErr <= 1'b0;
      end else begin
         r_measValid <= 1'b0;
         if (!i_meas_en) begin
            r_state      <= ST_IDLE;
            r_cnt        <= CNT_ZERO;
            r_timeoutErr <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_cnt   <= CNT_ZERO;
                  r_state <= ST_ARM;
               end
               ST_ARM: begin
                  if (w_rise) begin
                     r_cnt   <= CNT_ONE;
                     r_state <= ST_HIGH;
                  end
               end
               ST_HIGH: begin
                  if (w_fall) begin
                     r_hiReg <= r_cnt;
                     r_cnt   <= r_cnt + CNT_ONE;
                     r_state <= ST_LOW;
                  end else if (r_cnt == CNT_MAX) begin
                     r_timeoutErr <= 1'b1;
                     r_cnt        <= CNT_ZERO;
                     r_state      <= ST_ARM;
                  end else begin
                     r_cnt <= r_cnt + CNT_ONE;
                  end
               end
               ST_LOW: begin
                  // A rise closes the period and immediately opens the next one.
                  if (w_rise) begin
                     r_period    <= r_cnt;
                     r_highTime  <= r_hiReg;
                     r_measValid <= 1'b1;
                     r_cnt       <= CNT_ONE;
                     r_state     <= ST_HIGH;
                  end else if (r_cnt == CNT_MAX) begin
                     r_timeoutErr <= 1'b1;
                     r_cnt        <= CNT_ZERO;
                     r_state      <= ST_ARM;
                  end else begin
                     r_cnt <= r_cnt + CNT_ONE;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= CNT_ZERO;
               end
            endcase
         end
      end
   end

   assign o_period      = r_period;
   assign o_high_time   = r_highTime;
   assign o_meas_valid  = r_measValid;
   assign o_timeout_err = r_timeoutErr;
   assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_freq_duty_meter.sv
// Scoreboard bench for freq_duty_meter: stimulus pushes expected results,
// a negedge monitor pops and compares on every o_meas_valid strobe.
module tb_freq_duty_meter;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             measEn;
   logic             sigDrv;
   logic             useDiv;
   logic             sigIn;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] highTime;
   logic             measValid;
   logic             timeoutErr;
   logic             busy;

   logic [2:0] divCnt = 3'd0;
   logic       divOut;

   int vectorsApplied = 0;
   int miscompares    = 0;
   int cycleCount     = 0;
   int riseCycle      = 0;
   int expPeriodQ[$];
   int expHighQ[$];
   int stamps[$];
   int ep;
   int eh;

   freq_duty_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
      .i_clk_in      (clk),
      .i_rst_n       (rst_n),
      .i_sig_in      (sigIn),
      .i_meas_en     (measEn),
      .o_period      (period),
      .o_high_time   (highTime),
      .o_meas_valid  (measValid),
      .o_timeout_err (timeoutErr),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   // Divide-by-7 reference source, high for 4 of every 7 cycles.
   always @(posedge clk) divCnt <= (divCnt == 3'd6) ? 3'd0 : divCnt + 3'd1;
   assign divOut = (divCnt < 3'd4);
   assign sigIn  = useDiv ? divOut : sigDrv;

   always @(negedge clk) begin
      if (rst_n && measValid) begin
         stamps.push_back(cycleCount);
         vectorsApplied++;
         if (expPeriodQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpectedValid: got period=%0d high_time=%0d, expected no strobe",
                     period, highTime);
         end else begin
            ep = expPeriodQ.pop_front();
            eh = expHighQ.pop_front();
            if (int'(period) != ep || int'(highTime) != eh) begin
               miscompares++;
               $display("[TB] FAIL result: got period=%0d high_time=%0d, expected period=%0d high_time=%0d",
                        period, highTime, ep, eh);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectorsApplied++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives n periods of hi/lo; only rises after the first produce results.
   task automatic applyStimulus(input int hi, input int lo, input int n,
                                input int expP, input int expH);
      for (int i = 1; i < n; i++) begin
         expPeriodQ.push_back(expP);
         expHighQ.push_back(expH);
      end
      for (int i = 0; i < n; i++) begin
         if (i == 0) riseCycle = cycleCount;
         sigDrv = 1'b1;
         waitCycles(hi);
         sigDrv = 1'b0;
         waitCycles(lo);
      end
   endtask

   task automatic idleGap();
      measEn = 1'b0;
      sigDrv = 1'b0;
      useDiv = 1'b0;
      waitCycles(5);
   endtask

   task automatic enableAndArm();
      measEn = 1'b1;
      waitCycles(2);
   endtask

   initial begin
      rst_n  = 1'b0;
      measEn = 1'b0;
      sigDrv = 1'b0;
      useDiv = 1'b0;
      waitCycles(3);
      checkOutput("resetPeriod", int'(period), 0);
      checkOutput("resetHigh", int'(highTime), 0);
      checkOutput("resetValid", int'(measValid), 0);
      checkOutput("resetTimeout", int'(timeoutErr), 0);
      checkOutput("resetBusy", int'(busy), 0);
      rst_n = 1'b1;
      waitCycles(2);
      checkOutput("idleBusy", int'(busy), 0);

      $display("[TB] 3-high/4-low continuous measurement");
      stamps.delete();
      enableAndArm();
      checkOutput("armBusy", int'(busy), 1);
      applyStimulus(3, 4, 6, 7, 3);
      checkOutput("t1Count", stamps.size(), 5);
      if (stamps.size() >= 1)
         checkOutput("t1FirstLatency", stamps[0] - riseCycle, 10);
      for (int i = 1; i < stamps.size(); i++)
         checkOutput("t1Gap", stamps[i] - stamps[i-1], 7);

      $display("[TB] divide-by-7 source");
      idleGap();
      useDiv = 1'b1;
      for (int i = 0; i < 20 && divCnt != 3'd4; i++) @(negedge clk);
      checkOutput("divPhase", int'(divCnt), 4);
      for (int i = 0; i < 4; i++) begin
         expPeriodQ.push_back(7);
         expHighQ.push_back(4);
      end
      measEn = 1'b1;
      waitCycles(37);
      measEn = 1'b0;
      useDiv = 1'b0;
      waitCycles(2);
      checkOutput("divQueueEmpty", expPeriodQ.size(), 0);

      $display("[TB] timeout on stuck-high input");
      idleGap();
      enableAndArm();
      sigDrv = 1'b1;
      waitCycles(257);
      checkOutput("timeoutBefore", int'(timeoutErr), 0);
      waitCycles(1);
      checkOutput("timeoutAt255", int'(timeoutErr), 1);
      checkOutput("timeoutBusy", int'(busy), 1);
      sigDrv = 1'b0;
      waitCycles(5);
      checkOutput("armIgnoresFall", int'(busy), 1);
      applyStimulus(2, 2, 5, 4, 2);
      waitCycles(4);
      checkOutput("timeoutSticky", int'(timeoutErr), 1);
      checkOutput("resumePeriod", int'(period), 4);
      measEn = 1'b0;
      waitCycles(1);
      checkOutput("timeoutCleared", int'(timeoutErr), 0);
      checkOutput("disableBusy", int'(busy), 0);

      $display("[TB] meas_en dropped during LOW");
      idleGap();
      enableAndArm();
      applyStimulus(3, 4, 3, 7, 3);
      waitCycles(2);
      measEn = 1'b0;
      waitCycles(1);
      checkOutput("dropBusy", int'(busy), 0);
      checkOutput("dropPeriodHeld", int'(period), 7);
      checkOutput("dropHighHeld", int'(highTime), 3);
      checkOutput("dropTimeout", int'(timeoutErr), 0);
      measEn = 1'b1;
      waitCycles(2);
      applyStimulus(3, 4, 3, 7, 3);

      $display("[TB] reset pulse during HIGH");
      idleGap();
      enableAndArm();
      sigDrv = 1'b1;
      waitCycles(5);
      rst_n  = 1'b0;
      sigDrv = 1'b0;
      waitCycles(1);
      checkOutput("midResetPeriod", int'(period), 0);
      checkOutput("midResetHigh", int'(highTime), 0);
      checkOutput("midResetValid", int'(measValid), 0);
      checkOutput("midResetTimeout", int'(timeoutErr), 0);
      checkOutput("midResetBusy", int'(busy), 0);
      waitCycles(2);
      rst_n = 1'b1;
      waitCycles(2);
      applyStimulus(5, 5, 3, 10, 5);

      $display("[TB] rise coincides with meas_en falling");
      idleGap();
      enableAndArm();
      sigDrv = 1'b1;
      waitCycles(2);
      measEn = 1'b0;
      waitCycles(1);
      checkOutput("edgeVsDisableBusy", int'(busy), 0);
      waitCycles(10);
      checkOutput("edgeVsDisableIdle", int'(busy), 0);
      sigDrv = 1'b0;

      waitCycles(10);
      checkOutput("scoreboardEmpty", expPeriodQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
